// File: rtl/rns_cmp_arbiter.sv
// rns_cmp_arbiter
// Round-robin arbiter and sequencer that shares a single (9,8,7) RNS magnitude
// comparator among NUM_REQ requesters. One operand pair is accepted per
// transaction; the tagged less/equal/greater result and a range-error flag are
// returned two cycles later and held until the consumer accepts them.
//
// Ports:
//   clk_in         - clock, rising edge active
//   rst_n_in       - asynchronous active-low reset
//   req_valid_in   - per-requester operand-valid
//   req_ready_out  - one-hot grant (combinational, IDLE only)
//   a1_in/b1_in    - X/Y residues mod 9, 4 bits per requester
//   a2_in/b2_in    - X/Y residues mod 8, 3 bits per requester
//   a3_in/b3_in    - X/Y residues mod 7, 3 bits per requester
//   rsp_valid_out  - result available
//   rsp_ready_in   - consumer accepts result
//   rsp_id_out     - index of the requester owning the result
//   rsp_le_out/rsp_eq_out/rsp_gr_out - X<Y, X==Y, X>Y
//   rsp_err_out    - some residue of the pair is out of range
module rns_cmp_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic [NUM_REQ-1:0]   req_valid_in,
    output logic [NUM_REQ-1:0]   req_ready_out,
    input  logic [4*NUM_REQ-1:0] a1_in,
    input  logic [3*NUM_REQ-1:0] a2_in,
    input  logic [3*NUM_REQ-1:0] a3_in,
    input  logic [4*NUM_REQ-1:0] b1_in,
    input  logic [3*NUM_REQ-1:0] b2_in,
    input  logic [3*NUM_REQ-1:0] b3_in,
    output logic                 rsp_valid_out,
    input  logic                 rsp_ready_in,
    output logic [ID_W-1:0]      rsp_id_out,
    output logic                 rsp_le_out,
    output logic                 rsp_eq_out,
    output logic                 rsp_gr_out,
    output logic                 rsp_err_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // CRT reconstruction for moduli (9,8,7), M = 504:
    // X = (280*r9 + 441*r8 + 288*r7) mod 504.
    function automatic logic [9:0] rns_to_bin(input logic [3:0] r9,
                                              input logic [2:0] r8,
                                              input logic [2:0] r7);
        logic [13:0] acc;
        acc = 14'd280 * {10'd0, r9} + 14'd441 * {11'd0, r8} + 14'd288 * {11'd0, r7};
        return 10'(acc % 14'd504);
    endfunction

    // Magnitude comparator, result packed as {lt, eq, gt}.
    function automatic logic [2:0] compare_9_8_7(input logic [3:0] x1,
                                                 input logic [2:0] x2,
                                                 input logic [2:0] x3,
                                                 input logic [3:0] y1,
                                                 input logic [2:0] y2,
                                                 input logic [2:0] y3);
        logic [9:0] xv;
        logic [9:0] yv;
        xv = rns_to_bin(x1, x2, x3);
        yv = rns_to_bin(y1, y2, y3);
        if (xv < yv) begin
            return 3'b100;
        end else if (xv == yv) begin
            return 3'b010;
        end else begin
            return 3'b001;
        end
    endfunction

    // Mod-9 residue must be <= 8, mod-7 residue must be <= 6; mod-8 always legal.
    function automatic logic range_err(input logic [3:0] x1, input logic [3:0] y1,
                                       input logic [2:0] x3, input logic [2:0] y3);
        return (x1 > 4'd8) | (y1 > 4'd8) | (x3 == 3'd7) | (y3 == 3'd7);
    endfunction

    state_t              state_r;
    logic [ID_W-1:0]     ptr_r;
    logic [ID_W-1:0]     tag_r;
    logic [3:0]          op_a1_r;
    logic [2:0]          op_a2_r;
    logic [2:0]          op_a3_r;
    logic [3:0]          op_b1_r;
    logic [2:0]          op_b2_r;
    logic [2:0]          op_b3_r;

    logic                found_s;
    logic [ID_W-1:0]     cand_s;
    logic [ID_W-1:0]     win_s;
    logic [NUM_REQ-1:0]  grant_s;
    logic                xfer_s;
    logic [ID_W-1:0]     ptr_next_s;
    logic [3:0]          sel_a1_s;
    logic [2:0]          sel_a2_s;
    logic [2:0]          sel_a3_s;
    logic [3:0]          sel_b1_s;
    logic [2:0]          sel_b2_s;
    logic [2:0]          sel_b3_s;
    logic [2:0]          cmp_s;
    logic                err_s;

    // Rotating priority search: first valid requester at or after ptr, with wrap.
    always_comb begin
        found_s = 1'b0;
        cand_s  = '0;
        win_s   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s  = ID_W'((int'(ptr_r) + k) % NUM_REQ);
            win_s   = (!found_s && req_valid_in[cand_s]) ? cand_s : win_s;
            found_s = found_s | req_valid_in[cand_s];
        end
        if ((state_r == ST_IDLE) && found_s) begin
            grant_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_s;
        end else begin
            grant_s = '0;
        end
    end

    // One-hot OR-mux of the granted requester's operand slices.
    always_comb begin
        sel_a1_s = 4'd0;
        sel_a2_s = 3'd0;
        sel_a3_s = 3'd0;
        sel_b1_s = 4'd0;
        sel_b2_s = 3'd0;
        sel_b3_s = 3'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sel_a1_s = sel_a1_s | (a1_in[4*k +: 4] & {4{grant_s[k]}});
            sel_a2_s = sel_a2_s | (a2_in[3*k +: 3] & {3{grant_s[k]}});
            sel_a3_s = sel_a3_s | (a3_in[3*k +: 3] & {3{grant_s[k]}});
            sel_b1_s = sel_b1_s | (b1_in[4*k +: 4] & {4{grant_s[k]}});
            sel_b2_s = sel_b2_s | (b2_in[3*k +: 3] & {3{grant_s[k]}});
            sel_b3_s = sel_b3_s | (b3_in[3*k +: 3] & {3{grant_s[k]}});
        end
    end

    assign req_ready_out = grant_s;
    assign xfer_s        = |(req_valid_in & grant_s);
    assign ptr_next_s    = (win_s == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : (win_s + ID_W'(1));
    assign cmp_s         = compare_9_8_7(op_a1_r, op_a2_r, op_a3_r, op_b1_r, op_b2_r, op_b3_r);
    assign err_s         = range_err(op_a1_r, op_b1_r, op_a3_r, op_b3_r);

    // Sequencer FSM: accept in IDLE, evaluate in CMP, hold result in RESP.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r       <= ST_IDLE;
            ptr_r         <= '0;
            tag_r         <= '0;
            op_a1_r       <= 4'd0;
            op_a2_r       <= 3'd0;
            op_a3_r       <= 3'd0;
            op_b1_r       <= 4'd0;
            op_b2_r       <= 3'd0;
            op_b3_r       <= 3'd0;
            rsp_valid_out <= 1'b0;
            rsp_id_out    <= '0;
            rsp_le_out    <= 1'b0;
            rsp_eq_out    <= 1'b0;
            rsp_gr_out    <= 1'b0;
            rsp_err_out   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (xfer_s) begin
                        op_a1_r <= sel_a1_s;
                        op_a2_r <= sel_a2_s;
                        op_a3_r <= sel_a3_s;
                        op_b1_r <= sel_b1_s;
                        op_b2_r <= sel_b2_s;
                        op_b3_r <= sel_b3_s;
                        tag_r   <= win_s;
                        ptr_r   <= ptr_next_s;
                        state_r <= ST_CMP;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CMP: begin
                    rsp_id_out    <= tag_r;
                    rsp_err_out   <= err_s;
                    // An out-of-range pair has no meaningful ordering.
                    {rsp_le_out, rsp_eq_out, rsp_gr_out} <= err_s ? 3'b000 : cmp_s;
                    rsp_valid_out <= 1'b1;
                    state_r       <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready_in) begin
                        rsp_valid_out <= 1'b0;
                        state_r       <= ST_IDLE;
                    end else begin
                        state_r       <= ST_RESP;
                    end
                end
                default: begin
                    rsp_valid_out <= 1'b0;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rns_cmp_arbiter.sv
// tb_rns_cmp_arbiter
// Directed self-checking bench for rns_cmp_arbiter with NUM_REQ = 4.
// Inputs are driven just after the falling edge and outputs are checked 1 ns
// later, well away from the rising edge.
module tb_rns_cmp_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [4*N-1:0] a1;
    logic [3*N-1:0] a2;
    logic [3*N-1:0] a3;
    logic [4*N-1:0] b1;
    logic [3*N-1:0] b2;
    logic [3*N-1:0] b3;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IW-1:0]  rsp_id;
    logic           rsp_le;
    logic           rsp_eq;
    logic           rsp_gr;
    logic           rsp_err;
    logic [3:0]     flags;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    // Expected {le,eq,gr,err} for round-robin requester i: X=i, Y=2.
    logic [3:0] rr_exp [4] = '{4'b1000, 4'b1000, 4'b0100, 4'b0010};

    rns_cmp_arbiter #(.NUM_REQ(N)) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .req_valid_in  (req_valid),
        .req_ready_out (req_ready),
        .a1_in         (a1),
        .a2_in         (a2),
        .a3_in         (a3),
        .b1_in         (b1),
        .b2_in         (b2),
        .b3_in         (b3),
        .rsp_valid_out (rsp_valid),
        .rsp_ready_in  (rsp_ready),
        .rsp_id_out    (rsp_id),
        .rsp_le_out    (rsp_le),
        .rsp_eq_out    (rsp_eq),
        .rsp_gr_out    (rsp_gr),
        .rsp_err_out   (rsp_err)
    );

    assign flags = {rsp_le, rsp_eq, rsp_gr, rsp_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put_ops(input int r, input logic [3:0] x1, input logic [2:0] x2,
                           input logic [2:0] x3, input logic [3:0] y1,
                           input logic [2:0] y2, input logic [2:0] y3);
        a1[4*r +: 4] = x1;
        a2[3*r +: 3] = x2;
        a3[3*r +: 3] = x3;
        b1[4*r +: 4] = y1;
        b2[3*r +: 3] = y2;
        b3[3*r +: 3] = y3;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_id"},    32'(rsp_id),    32'd0);
        chk({tag, "_flags"}, 32'(flags),     32'd0);
    endtask

    // One complete transaction from a lone requester with rsp_ready high.
    task automatic txn(input string tag, input int r, input logic [3:0] x1,
                       input logic [2:0] x2, input logic [2:0] x3, input logic [3:0] y1,
                       input logic [2:0] y2, input logic [2:0] y3,
                       input int exp_id, input logic [3:0] exp_flags);
        @(negedge clk);
        put_ops(r, x1, x2, x3, y1, y2, y3);
        req_valid    = '0;
        req_valid[r] = 1'b1;
        #1;
        chk({tag, "_grant"}, 32'(req_ready), 32'd1 << r);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk({tag, "_cmp_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_cmp_valid"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_id"},    32'(rsp_id),    32'(exp_id));
        chk({tag, "_flags"}, 32'(flags),     32'(exp_flags));
        @(negedge clk);
        #1;
        chk({tag, "_done"},  32'(rsp_valid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        a1 = '0; a2 = '0; a3 = '0;
        b1 = '0; b2 = '0; b3 = '0;

        // Reset state
        @(negedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin: all four valid, grants 0,1,2,3,0 every 3 cycles
        @(negedge clk);
        for (int i = 0; i < N; i++) put_ops(i, 4'(i), 3'(i), 3'(i), 4'd2, 3'd2, 3'd2);
        req_valid = 4'b1111;
        for (int c = 0; c < 15; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (c % 3 == 0) chk("rr_grant", 32'(req_ready), 32'd1 << ((c / 3) % 4));
            else            chk("rr_grant", 32'(req_ready), 32'd0);
            if (c % 3 == 2) begin
                chk("rr_valid", 32'(rsp_valid), 32'd1);
                chk("rr_id",    32'(rsp_id),    32'((c / 3) % 4));
                chk("rr_flags", 32'(flags),     32'(rr_exp[(c / 3) % 4]));
            end else begin
                chk("rr_valid", 32'(rsp_valid), 32'd0);
            end
        end
        req_valid = '0;

        // Less-than: X=5 (5,5,5), Y=250 (7,2,5)
        txn("lt", 0, 4'd5, 3'd5, 3'd5, 4'd7, 3'd2, 3'd5, 0, 4'b1000);
        // Equal: X=Y=100 (1,4,2)
        txn("eq", 2, 4'd1, 3'd4, 3'd2, 4'd1, 3'd4, 3'd2, 2, 4'b0100);
        // Greater: X=300 (3,4,6), Y=17 (8,1,3)
        txn("gt", 2, 4'd3, 3'd4, 3'd6, 4'd8, 3'd1, 3'd3, 2, 4'b0010);
        // Range error: a1=9, then b3=7
        txn("err_a1", 1, 4'd9, 3'd0, 3'd0, 4'd0, 3'd0, 3'd0, 1, 4'b0001);
        txn("err_b3", 1, 4'd1, 3'd1, 3'd1, 4'd0, 3'd0, 3'd7, 1, 4'b0001);

        // Backpressure: requester 3 (X=300, Y=100), rsp_ready low for 5 RESP cycles
        @(negedge clk);
        rsp_ready = 1'b0;
        put_ops(3, 4'd3, 3'd4, 3'd6, 4'd1, 3'd4, 3'd2);
        req_valid = 4'b1000;
        #1;
        chk("bp_grant", 32'(req_ready), 32'h8);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("bp_cmp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        // A request appearing in RESP must wait for IDLE
        put_ops(0, 4'd5, 3'd5, 3'd5, 4'd7, 3'd2, 3'd5);
        req_valid = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_id",    32'(rsp_id),    32'd3);
            chk("bp_flags", 32'(flags),     32'b0010);
            chk("bp_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_done",  32'(rsp_valid), 32'd0);
        chk("bp_wrap",  32'(req_ready), 32'h1);

        // Reset during CMP: requester 0 was just granted
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("cmpres_valid_pre", 32'(rsp_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        chk_zero("cmp_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("cmp_reset_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // Reset during RESP
        @(negedge clk);
        rsp_ready = 1'b0;
        put_ops(1, 4'd1, 3'd4, 3'd2, 4'd1, 3'd4, 3'd2);
        req_valid = 4'b0010;
        #1;
        chk("respres_grant", 32'(req_ready), 32'h2);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        chk("respres_valid_pre", 32'(rsp_valid), 32'd1);
        chk("respres_flags_pre", 32'(flags),     32'b0100);
        rst_n = 1'b0;
        #1;
        chk_zero("resp_reset");
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("resp_reset_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // Pointer is back at 0: 0 beats 3, 3 wins only when alone
        @(negedge clk);
        req_valid = 4'b1001;
        #1;
        chk("ptr0_both", 32'(req_ready), 32'h1);
        req_valid = 4'b1000;
        #1;
        chk("ptr0_only3", 32'(req_ready), 32'h8);
        req_valid = '0;
        #1;
        chk("ptr0_none", 32'(req_ready), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
